// File: rtl/wormhole_output_arbiter.sv
// Round-robin, packet-locking arbiter for one router output port; grant is 0-cycle combinational.
// Optional sticky protocol-error detection is built only when WH_ARB_ERR_EN is defined.
module wormhole_output_arbiter #(
  parameter int NUM_PORTS = 5,
  parameter int OP_SIZE   = 3,
  parameter int TYPE_SIZE = 2,
  parameter int CNT_W     = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           req,
  input  logic [NUM_PORTS*TYPE_SIZE-1:0] flit_type,
  input  logic                           ON_OFF_signal,
  output logic [NUM_PORTS-1:0]           grant,
  output logic                           wr_en,
  output logic                           locked,
  output logic [OP_SIZE-1:0]             owner,
  output logic [CNT_W-1:0]               pkt_cnt,
  output logic                           err
);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  localparam logic [TYPE_SIZE-1:0] T_HEAD = TYPE_SIZE'(0);
  localparam logic [TYPE_SIZE-1:0] T_TAIL = TYPE_SIZE'(2);
  localparam logic [TYPE_SIZE-1:0] T_HT   = TYPE_SIZE'(3);
  localparam logic [OP_SIZE:0]     NP_W   = (OP_SIZE+1)'(NUM_PORTS);

  state_t             state_q;
  logic [OP_SIZE-1:0] ptr_q;
  logic [OP_SIZE-1:0] owner_q;
  logic [CNT_W-1:0]   pkt_cnt_q;
  logic               locked_q;

  logic [TYPE_SIZE-1:0]   ft [NUM_PORTS];
  logic [NUM_PORTS-1:0]   eligible;
  logic [2*NUM_PORTS-1:0] dbl;
  logic [NUM_PORTS-1:0]   rot;
  logic [OP_SIZE-1:0]     off;
  logic [OP_SIZE-1:0]     win_idx;
  logic                   win_found;
  logic [TYPE_SIZE-1:0]   win_type;
  logic [TYPE_SIZE-1:0]   own_type;
  logic                   own_req;
  logic [NUM_PORTS-1:0]   grant_c;
  logic                   xfer;

  function automatic logic [OP_SIZE-1:0] wrap_add(input logic [OP_SIZE-1:0] a,
                                                  input logic [OP_SIZE-1:0] b);
    logic [OP_SIZE:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= NP_W) s = s - NP_W;
    return s[OP_SIZE-1:0];
  endfunction

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      ft[i]       = flit_type[i*TYPE_SIZE +: TYPE_SIZE];
      eligible[i] = req[i] && (ft[i] == T_HEAD || ft[i] == T_HT);
    end
  end

  // Rotate eligibility so bit 0 is the ptr position; lowest set bit is the winner.
  always_comb begin
    dbl = {eligible, eligible} >> ptr_q;
    rot = dbl[NUM_PORTS-1:0];
    off = '0;
    for (int k = NUM_PORTS-1; k >= 0; k--) begin
      if (rot[k]) off = OP_SIZE'(k);
    end
    win_found = |rot;
    win_idx   = wrap_add(ptr_q, off);
  end

  always_comb begin
    win_type = T_HEAD;
    own_type = T_HEAD;
    own_req  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (win_idx == OP_SIZE'(i)) win_type = ft[i];
      if (owner_q == OP_SIZE'(i)) begin
        own_type = ft[i];
        own_req  = req[i];
      end
    end
  end

  always_comb begin
    grant_c = '0;
    if (ON_OFF_signal) begin
      if (state_q == S_IDLE) begin
        if (win_found) grant_c[win_idx] = 1'b1;
      end else begin
        grant_c[owner_q] = own_req;
      end
    end
  end

  // Grant is forced low during reset so no buffer is popped while the state is being cleared.
  assign grant = rst ? grant_c : '0;
  assign wr_en = |grant;
  assign xfer  = |grant_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      pkt_cnt_q <= '0;
      locked_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (xfer) begin
            if (win_type == T_HEAD) begin
              state_q  <= S_LOCKED;
              owner_q  <= win_idx;
              locked_q <= 1'b1;
            end else begin
              pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
              ptr_q     <= wrap_add(win_idx, OP_SIZE'(1));
            end
          end
        end
        S_LOCKED: begin
          if (xfer && own_type == T_TAIL) begin
            state_q   <= S_IDLE;
            pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
            ptr_q     <= wrap_add(owner_q, OP_SIZE'(1));
            owner_q   <= '0;
            locked_q  <= 1'b0;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign locked  = locked_q;
  assign owner   = owner_q;
  assign pkt_cnt = pkt_cnt_q;

`ifdef WH_ARB_ERR_EN
  logic [4:0] stall_q, stall_d;
  logic       err_q, err_d;
  logic       lock_err, idle_stuck;

  // A stray body/tail in IDLE with no head to serve means the upstream lost a packet boundary.
  always_comb begin
    lock_err   = (state_q == S_LOCKED) && own_req && (own_type == T_HEAD || own_type == T_HT);
    idle_stuck = (state_q == S_IDLE) && |(req & ~eligible) && !(|eligible);
    stall_d    = idle_stuck ? ((stall_q == 5'd31) ? stall_q : stall_q + 5'd1) : 5'd0;
    err_d      = err_q || lock_err || (idle_stuck && stall_q >= 5'd15);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_wormhole_output_arbiter.sv
// Directed bench for wormhole_output_arbiter: expected grants are queued by the stimulus and
// popped by a negedge monitor whenever the DUT drives a transfer.
module tb_wormhole_output_arbiter;

  localparam logic [1:0] H  = 2'b00;
  localparam logic [1:0] B  = 2'b01;
  localparam logic [1:0] T  = 2'b10;
  localparam logic [1:0] HT = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] req;
  logic [9:0] flit_type;
  logic       ON_OFF_signal;
  logic [4:0] grant;
  logic       wr_en;
  logic       locked;
  logic [2:0] owner;
  logic [7:0] pkt_cnt;
  logic       err;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q [$];

  wormhole_output_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .flit_type(flit_type),
    .ON_OFF_signal(ON_OFF_signal), .grant(grant), .wr_en(wr_en),
    .locked(locked), .owner(owner), .pkt_cnt(pkt_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] ft(input logic [1:0] t0, input logic [1:0] t1,
                                    input logic [1:0] t2, input logic [1:0] t3,
                                    input logic [1:0] t4);
    return {t4, t3, t2, t1, t0};
  endfunction

  // Drive one cycle of inputs; a nonzero eg is the grant the monitor must see this cycle.
  task automatic step(input logic [4:0] r, input logic [9:0] t, input logic on,
                      input logic [4:0] eg);
    req = r;
    flit_type = t;
    ON_OFF_signal = on;
    if (eg != 5'b0) exp_q.push_back(eg);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [4:0] e;
    chk("wr_en_vs_grant", int'(wr_en), int'(|grant));
    if (grant != 5'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_grant", int'(grant), 0);
      end else begin
        e = exp_q.pop_front();
        chk("grant", int'(grant), int'(e));
      end
    end
  end

  initial begin
    logic [9:0] allh;
    logic [9:0] t;
    logic [4:0] r;
    logic [4:0] oh;
    int exp_err;
`ifdef WH_ARB_ERR_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    allh = ft(H, H, H, H, H);

    rst = 1'b0;
    req = 5'b11111;
    flit_type = allh;
    ON_OFF_signal = 1'b1;
    #2;
    chk("rst_grant", int'(grant), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_pkt_cnt", int'(pkt_cnt), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_owner", int'(owner), 0);
    chk("rst_err", int'(err), 0);
    @(posedge clk);
    #1;
    chk("rst_grant_held", int'(grant), 0);
    rst = 1'b1;

    // Contention: each input sends head/body/tail, served in round-robin order.
    for (int p = 0; p < 5; p++) begin
      oh = 5'(1 << p);
      r = ~5'((1 << p) - 1);
      step(r, allh, 1'b1, oh);
      chk("cont_locked", int'(locked), 1);
      chk("cont_owner", int'(owner), p);
      t = allh;
      t[2*p +: 2] = B;
      step(r, t, 1'b1, oh);
      t[2*p +: 2] = T;
      step(r, t, 1'b1, oh);
      chk("cont_unlocked", int'(locked), 0);
      chk("cont_owner_clr", int'(owner), 0);
      chk("cont_pkt_cnt", int'(pkt_cnt), p + 1);
    end
    chk("cont_total", int'(pkt_cnt), 5);

    // Lock hold: E owns the port, stalls, while W waits with a head.
    step(5'b00010, allh, 1'b1, 5'b00010);
    chk("hold_owner", int'(owner), 1);
    for (int i = 0; i < 4; i++) begin
      step(5'b01000, allh, 1'b1, 5'b0);
      chk("hold_locked", int'(locked), 1);
      chk("hold_owner_stall", int'(owner), 1);
    end
    step(5'b01010, ft(H, B, H, H, H), 1'b1, 5'b00010);
    step(5'b01010, ft(H, T, H, H, H), 1'b1, 5'b00010);
    chk("hold_unlocked", int'(locked), 0);
    chk("hold_pkt_cnt", int'(pkt_cnt), 6);
    step(5'b01000, allh, 1'b1, 5'b01000);
    chk("w_owner", int'(owner), 3);

    // Back-pressure mid-packet.
    for (int i = 0; i < 3; i++) begin
      step(5'b01000, ft(H, H, H, B, H), 1'b0, 5'b0);
      chk("bp_locked", int'(locked), 1);
      chk("bp_owner", int'(owner), 3);
    end
    step(5'b01000, ft(H, H, H, B, H), 1'b1, 5'b01000);
    step(5'b01000, ft(H, H, H, T, H), 1'b1, 5'b01000);
    chk("bp_pkt_cnt", int'(pkt_cnt), 7);
    chk("bp_unlocked", int'(locked), 0);

    // Head-tail packets from L then N with ptr at L.
    step(5'b10001, ft(HT, H, H, H, HT), 1'b1, 5'b10000);
    chk("ht_l_locked", int'(locked), 0);
    chk("ht_l_pkt_cnt", int'(pkt_cnt), 8);
    step(5'b00001, ft(HT, H, H, H, H), 1'b1, 5'b00001);
    chk("ht_n_locked", int'(locked), 0);
    chk("ht_n_pkt_cnt", int'(pkt_cnt), 9);

    // Body and tail never win in IDLE.
    step(5'b00100, ft(H, H, B, H, H), 1'b1, 5'b0);
    step(5'b00100, ft(H, H, T, H, H), 1'b1, 5'b0);
    chk("idle_body_locked", int'(locked), 0);
    chk("idle_body_pkt_cnt", int'(pkt_cnt), 9);

    // Owner N presents a second head while locked.
    step(5'b00001, allh, 1'b1, 5'b00001);
    chk("err_pre", int'(err), 0);
    chk("err_owner", int'(owner), 0);
    chk("err_locked", int'(locked), 1);
    step(5'b00001, allh, 1'b1, 5'b00001);
    chk("err_set", int'(err), exp_err);
    step(5'b00001, ft(T, H, H, H, H), 1'b1, 5'b00001);
    chk("err_pkt_cnt", int'(pkt_cnt), 10);
    step(5'b00000, allh, 1'b1, 5'b0);
    chk("err_sticky", int'(err), exp_err);

    // Counter wrap.
    for (int i = 0; i < 245; i++) step(5'b00001, ft(HT, H, H, H, H), 1'b1, 5'b00001);
    chk("wrap_255", int'(pkt_cnt), 255);
    step(5'b00001, ft(HT, H, H, H, H), 1'b1, 5'b00001);
    chk("wrap_0", int'(pkt_cnt), 0);
    chk("wrap_locked", int'(locked), 0);

    // Reset in the middle of a packet drops the lock.
    step(5'b00010, allh, 1'b1, 5'b00010);
    chk("mid_owner", int'(owner), 1);
    rst = 1'b0;
    req = 5'b00010;
    flit_type = ft(H, B, H, H, H);
    #1;
    chk("mid_rst_grant", int'(grant), 0);
    chk("mid_rst_locked", int'(locked), 0);
    chk("mid_rst_owner", int'(owner), 0);
    chk("mid_rst_err", int'(err), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(5'b00010, ft(H, B, H, H, H), 1'b1, 5'b0);
    chk("post_rst_locked", int'(locked), 0);
    step(5'b11111, allh, 1'b1, 5'b00001);
    chk("post_rst_owner", int'(owner), 0);
    chk("post_rst_lock", int'(locked), 1);
    step(5'b00000, allh, 1'b1, 5'b0);

    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
